teatris_animador_fim: RTL and testbench
=======================================

TEATRIS_ANIMADOR_FIM -- requirements
Module: teatris_animador_fim

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clock and reset.
REQ-002 Parameter LINHAS SHALL default to 8 and set the matrix row count.
REQ-003 Parameter COLUNAS SHALL default to 8 and set the matrix column count.
REQ-004 Parameter QUADROS SHALL default to 4 and set the animation frame count (min 2).
REQ-005 Parameter TICKS_QUADRO SHALL default to 25 and set the tick pulses per frame (min 1).
REQ-006 Parameter LOOP SHALL default to 0; 1 means repeat forever, 0 means stop on the last frame.
REQ-007 The block SHALL have these ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- iniciar  in  1  start/restart pulse.
- parar  in  1  abort to blank.
- tick  in  1  timebase enable, one cycle wide.
- padrao  out  LINHAS*COLUNAS  registered pattern; row 0 is the MSB slice.
- quadro  out  max(1,$clog2(QUADROS))  current frame index.
- ativo  out  1  high while playing.
- concluido  out  1  one-cycle pulse when the last frame's period expires.

Function
REQ-008 The FSM SHALL have three states: OCIOSO (blank), TOCANDO (playing) and FINAL (holding the last frame).
REQ-009 In OCIOSO, iniciar SHALL enter TOCANDO with quadro=0 and the tick counter at 0.
REQ-010 In TOCANDO, each tick SHALL increment the tick counter.
REQ-011 On a tick with counter==TICKS_QUADRO-1, the counter SHALL clear and quadro SHALL advance by one.
REQ-012 On that wrap at quadro==QUADROS-1, concluido SHALL pulse for one cycle, and then:
- LOOP=1: quadro wraps to 0 and the FSM stays in TOCANDO.
- LOOP=0: the FSM goes to FINAL and quadro holds QUADROS-1.
REQ-013 padrao SHALL equal ROM[quadro] with one cycle of latency, both in TOCANDO and FINAL.
REQ-014 padrao SHALL go to all-zero one cycle after the FSM enters OCIOSO.
REQ-015 ROM contents SHALL be as follows:
- Base pattern for 8x8 is FIM = 64'h085CFE0FFF0FBF0F; for any other size it is all-ones.
- Frame k reveals the bottom floor((k+1)*LINHAS/QUADROS) rows of the base (least-significant rows) and zeroes the rest.
- Frame QUADROS-1 SHALL be the full base.
REQ-016 ativo SHALL be 1 exactly while the state is TOCANDO.
REQ-017 Priority SHALL be parar > iniciar > tick: parar in any state goes to OCIOSO, and iniciar in TOCANDO or FINAL restarts at frame 0 with the counter cleared.
REQ-018 A tick in the same cycle as iniciar SHALL be ignored (the counter stays 0).
REQ-019 In OCIOSO and FINAL, tick SHALL NOT advance quadro.

Reset
REQ-020 reset SHALL force state=OCIOSO, padrao=0, quadro=0, counter=0, ativo=0 and concluido=0 on the next clock edge, overriding all inputs, including in mid-animation.

Configuration
REQ-021 With TEATRIS_PISCA_EN defined, FINAL SHALL toggle padrao between frame QUADROS-1 and all-zero every TICKS_QUADRO ticks, starting with the frame shown.
REQ-022 Without TEATRIS_PISCA_EN, FINAL SHALL hold frame QUADROS-1 steadily and the blink logic SHALL be absent.

Structure
REQ-023 The FSM state encodings (OCIOSO=0, TOCANDO=1, FINAL=2) and the 8x8 FIM constant SHALL live in the shared teatris package/include.
REQ-024 The frame ROM SHALL be the sub-module teatris_rom_quadros, with parameters LINHAS, COLUNAS and QUADROS, a registered output and 1-cycle latency.

Verification
REQ-025 Basic playback: defaults, reset, then iniciar, then 25 ticks. The bench SHALL check:
- padrao = 64'h000000000000BF0F during frame 0.
- After the 25th tick, quadro=1 and padrao = 64'h00000000FF0FBF0F one cycle later.
REQ-026 Completion: defaults with 100 ticks. The bench SHALL check:
- concluido pulses once on the 100th tick.
- The state is FINAL, ativo=0 and padrao = 64'h085CFE0FFF0FBF0F held thereafter.
REQ-027 Loop mode: LOOP=1 with 100 ticks. The bench SHALL check that concluido pulses, quadro returns to 0 and ativo stays 1.
REQ-028 Priority: at frame 2, assert parar and iniciar in the same cycle. The bench SHALL check that the state is OCIOSO and padrao=0 one cycle later.
REQ-029 Restart and reset: assert iniciar together with tick in FINAL, then reset mid-TOCANDO. The bench SHALL check:
- After iniciar: quadro=0 and counter=0.
- After reset: every output is 0 on the next cycle.
REQ-030 Blink: TEATRIS_PISCA_EN defined, TICKS_QUADRO=2, in FINAL with 4 ticks. The bench SHALL check that padrao alternates FIM, 0, FIM.

Source files
------------

// File: rtl/teatris_pkg.sv
// teatris_pkg: shared FSM state encodings and the 8x8 "FIM" base pattern.
package teatris_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    TOCANDO = 2'd1,
    FINAL   = 2'd2
  } estado_t;
  localparam logic [63:0] FIM = 64'h085CFE0FFF0FBF0F;
endpackage

// File: rtl/teatris_rom_quadros.sv
// teatris_rom_quadros: frame ROM revealing the bottom rows of the base pattern, registered output.
module teatris_rom_quadros import teatris_pkg::*; #(
  parameter int LINHAS  = 8,
  parameter int COLUNAS = 8,
  parameter int QUADROS = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [(QUADROS>1?$clog2(QUADROS):1)-1:0] quadro_i,
  input  logic                                   apagar_i,
  output logic [LINHAS*COLUNAS-1:0]              padrao_o
);
  localparam int W = LINHAS * COLUNAS;
  logic [W-1:0] base, mascara, padrao_q;
  generate
    if (LINHAS == 8 && COLUNAS == 8) begin : g_fim
      assign base = FIM;
    end else begin : g_uns
      assign base = '1;
    end
  endgenerate
  // Row 0 sits in the MSB slice, so the bottom rows are the low-order slices.
  always_comb begin
    mascara = '0;
    for (int r = 0; r < LINHAS; r++)
      if (r < (int'(quadro_i) + 1) * LINHAS / QUADROS) mascara[r*COLUNAS +: COLUNAS] = '1;
  end
  always_ff @(posedge clock) begin
    if (reset) padrao_q <= '0;
    else padrao_q <= apagar_i ? '0 : base & mascara;
  end
  assign padrao_o = padrao_q;
endmodule

// File: rtl/teatris_animador_fim.sv
// teatris_animador_fim: plays the FIM reveal animation frame by frame on tick pulses.
// Optional TEATRIS_PISCA_EN makes the final frame blink every TICKS_QUADRO ticks.
module teatris_animador_fim import teatris_pkg::*; #(
  parameter int LINHAS       = 8,
  parameter int COLUNAS      = 8,
  parameter int QUADROS      = 4,
  parameter int TICKS_QUADRO = 25,
  parameter int LOOP         = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   iniciar,
  input  logic                                   parar,
  input  logic                                   tick,
  output logic [LINHAS*COLUNAS-1:0]              padrao,
  output logic [(QUADROS>1?$clog2(QUADROS):1)-1:0] quadro,
  output logic                                   ativo,
  output logic                                   concluido
);
  localparam int QW = QUADROS > 1 ? $clog2(QUADROS) : 1;
  localparam int CW = TICKS_QUADRO > 1 ? $clog2(TICKS_QUADRO) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUADROS - 1);
  localparam logic [CW-1:0] CMAX = CW'(TICKS_QUADRO - 1);
  estado_t estado_q;
  logic [QW-1:0] quadro_q;
  logic [CW-1:0] cont_q;
  logic ativo_q, concluido_q, apagar;
`ifdef TEATRIS_PISCA_EN
  logic pisca_q;
  assign apagar = estado_q == OCIOSO || (estado_q == FINAL && !pisca_q);
`else
  assign apagar = estado_q == OCIOSO;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      quadro_q    <= '0;
      cont_q      <= '0;
      ativo_q     <= 1'b0;
      concluido_q <= 1'b0;
`ifdef TEATRIS_PISCA_EN
      pisca_q     <= 1'b1;
`endif
    end else begin
      concluido_q <= 1'b0;
      if (parar) begin
        estado_q <= OCIOSO;
        quadro_q <= '0;
        cont_q   <= '0;
        ativo_q  <= 1'b0;
      end else if (iniciar) begin
        estado_q <= TOCANDO;
        quadro_q <= '0;
        cont_q   <= '0;
        ativo_q  <= 1'b1;
`ifdef TEATRIS_PISCA_EN
        pisca_q  <= 1'b1;
`endif
      end else if (tick && estado_q == TOCANDO) begin
        if (cont_q == CMAX) begin
          cont_q <= '0;
          if (quadro_q == QMAX) begin
            concluido_q <= 1'b1;
            if (LOOP != 0) quadro_q <= '0;
            else begin
              estado_q <= FINAL;
              ativo_q  <= 1'b0;
            end
          end else quadro_q <= quadro_q + QW'(1);
        end else cont_q <= cont_q + CW'(1);
      end
`ifdef TEATRIS_PISCA_EN
      else if (tick && estado_q == FINAL) begin
        cont_q <= cont_q == CMAX ? '0 : cont_q + CW'(1);
        if (cont_q == CMAX) pisca_q <= !pisca_q;
      end
`endif
    end
  end
  teatris_rom_quadros #(.LINHAS(LINHAS), .COLUNAS(COLUNAS), .QUADROS(QUADROS)) u_rom (
    .clock    (clock),
    .reset    (reset),
    .quadro_i (quadro_q),
    .apagar_i (apagar),
    .padrao_o (padrao)
  );
  assign quadro    = quadro_q;
  assign ativo     = ativo_q;
  assign concluido = concluido_q;
endmodule

// File: tb/tb_teatris_animador_fim.sv
// tb_teatris_animador_fim: vector table, corner sequences and random stimulus against a frame-level model.
module tb_teatris_animador_fim;
  localparam logic [63:0] FIM_C = 64'h085CFE0FFF0FBF0F;
`ifdef TEATRIS_PISCA_EN
  localparam bit PISCA = 1'b1;
`else
  localparam bit PISCA = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, parar = 1'b0, tick = 1'b0;
  logic [63:0] pad [3];
  logic [1:0]  qd  [3];
  logic        at  [3], cc [3];
  int n_tests = 0, n_fail = 0;
  always #5 clock = ~clock;

  teatris_animador_fim dut0 (.clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar), .tick(tick),
    .padrao(pad[0]), .quadro(qd[0]), .ativo(at[0]), .concluido(cc[0]));
  teatris_animador_fim #(.LOOP(1)) dut1 (.clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .tick(tick), .padrao(pad[1]), .quadro(qd[1]), .ativo(at[1]), .concluido(cc[1]));
  teatris_animador_fim #(.TICKS_QUADRO(2)) dut2 (.clock(clock), .reset(reset), .iniciar(iniciar),
    .parar(parar), .tick(tick), .padrao(pad[2]), .quadro(qd[2]), .ativo(at[2]), .concluido(cc[2]));

  // Model: mode 0 idle, 1 playing, 2 holding last frame; pad is the one-cycle-late display.
  int m_mode [3], m_frame [3], m_cnt [3];
  bit m_vis [3], m_done [3];
  logic [63:0] m_pad [3];

  function automatic logic [63:0] rom_ref(int k);
    int rows;
    rows = (k + 1) * 8 / 4;
    return rows >= 8 ? FIM_C : FIM_C & ((64'd1 << (rows * 8)) - 64'd1);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int t;
      logic [63:0] pn;
      t = (i == 2) ? 2 : 25;
      if (reset) begin
        m_mode[i] = 0; m_frame[i] = 0; m_cnt[i] = 0; m_vis[i] = 1; m_done[i] = 0; m_pad[i] = '0;
      end else begin
        pn = (m_mode[i] == 0 || (m_mode[i] == 2 && !m_vis[i])) ? 64'd0 : rom_ref(m_frame[i]);
        m_done[i] = 0;
        if (parar) begin
          m_mode[i] = 0; m_frame[i] = 0; m_cnt[i] = 0;
        end else if (iniciar) begin
          m_mode[i] = 1; m_frame[i] = 0; m_cnt[i] = 0; m_vis[i] = 1;
        end else if (tick && m_mode[i] == 1) begin
          m_cnt[i]++;
          if (m_cnt[i] == t) begin
            m_cnt[i] = 0;
            if (m_frame[i] == 3) begin
              m_done[i] = 1;
              if (i == 1) m_frame[i] = 0;
              else begin m_mode[i] = 2; m_vis[i] = 1; end
            end else m_frame[i]++;
          end
        end else if (PISCA && tick && m_mode[i] == 2) begin
          m_cnt[i]++;
          if (m_cnt[i] == t) begin m_cnt[i] = 0; m_vis[i] = !m_vis[i]; end
        end
        m_pad[i] = pn;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    model_step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m_pad%0d", i), pad[i], m_pad[i]);
      chk($sformatf("m_ativo%0d", i), 64'(at[i]), 64'(m_mode[i] == 1));
      chk($sformatf("m_conc%0d", i), 64'(cc[i]), 64'(m_done[i]));
      if (m_mode[i] != 0) chk($sformatf("m_quadro%0d", i), 64'(qd[i]), 64'(m_frame[i]));
    end
  endtask

  task automatic drive(bit r, bit i, bit p, bit t);
    reset = r; iniciar = i; parar = p; tick = t;
  endtask

  typedef struct {
    int rep; bit rst, ini, par, tk;
    logic [63:0] pad; logic [1:0] q; bit at, cc, ckq;
  } vec_t;
  vec_t tab [19];

  initial begin
    tab[0]  = '{1,  1,0,0,0, 64'h0,               2'd0, 0,0,1};
    tab[1]  = '{1,  0,1,0,0, 64'h0,               2'd0, 1,0,1};
    tab[2]  = '{1,  0,0,0,0, 64'h000000000000BF0F, 2'd0, 1,0,1};
    tab[3]  = '{24, 0,0,0,1, 64'h000000000000BF0F, 2'd0, 1,0,1};
    tab[4]  = '{1,  0,0,0,1, 64'h000000000000BF0F, 2'd1, 1,0,1};
    tab[5]  = '{1,  0,0,0,0, 64'h00000000FF0FBF0F, 2'd1, 1,0,1};
    tab[6]  = '{74, 0,0,0,1, FIM_C,               2'd3, 1,0,1};
    tab[7]  = '{1,  0,0,0,1, FIM_C,               2'd3, 0,1,1};
    tab[8]  = '{1,  0,0,0,0, FIM_C,               2'd3, 0,0,1};
    tab[9]  = '{10, 0,0,0,1, FIM_C,               2'd3, 0,0,1};
    tab[10] = '{1,  0,1,0,1, FIM_C,               2'd0, 1,0,1};
    tab[11] = '{24, 0,0,0,1, 64'h000000000000BF0F, 2'd0, 1,0,1};
    tab[12] = '{1,  0,0,0,1, 64'h000000000000BF0F, 2'd1, 1,0,1};
    tab[13] = '{25, 0,0,0,1, 64'h00000000FF0FBF0F, 2'd2, 1,0,1};
    tab[14] = '{1,  0,1,1,0, 64'h0000FE0FFF0FBF0F, 2'd0, 0,0,0};
    tab[15] = '{1,  0,0,0,0, 64'h0,               2'd0, 0,0,0};
    tab[16] = '{1,  0,1,0,0, 64'h0,               2'd0, 1,0,1};
    tab[17] = '{30, 0,0,0,1, 64'h00000000FF0FBF0F, 2'd1, 1,0,1};
    tab[18] = '{1,  1,1,0,1, 64'h0,               2'd0, 0,0,1};
    for (int v = 0; v < 19; v++) begin
      for (int r = 0; r < tab[v].rep; r++) begin
        drive(tab[v].rst, tab[v].ini, tab[v].par, tab[v].tk);
        cyc();
      end
      drive(0, 0, 0, 0);
      chk($sformatf("vec%0d_pad", v), pad[0], tab[v].pad);
      chk($sformatf("vec%0d_ativo", v), 64'(at[0]), 64'(tab[v].at));
      chk($sformatf("vec%0d_conc", v), 64'(cc[0]), 64'(tab[v].cc));
      if (tab[v].ckq) chk($sformatf("vec%0d_quadro", v), 64'(qd[0]), 64'(tab[v].q));
    end
    // Loop mode wraps to frame 0 and keeps playing.
    drive(1, 0, 0, 0); cyc();
    drive(0, 1, 0, 0); cyc();
    for (int r = 0; r < 99; r++) begin drive(0, 0, 0, 1); cyc(); end
    chk("loop_conc_pre", 64'(cc[1]), 64'd0);
    drive(0, 0, 0, 1); cyc();
    chk("loop_conc", 64'(cc[1]), 64'd1);
    chk("loop_quadro", 64'(qd[1]), 64'd0);
    chk("loop_ativo", 64'(at[1]), 64'd1);
    chk("noloop_conc", 64'(cc[0]), 64'd1);
    drive(0, 0, 0, 0); cyc();
    chk("loop_conc_once", 64'(cc[1]), 64'd0);
    chk("loop_ativo_hold", 64'(at[1]), 64'd1);
    // Final-frame blink (or steady hold without the blink option), two ticks per frame.
    drive(1, 0, 0, 0); cyc();
    drive(0, 1, 0, 0); cyc();
    for (int r = 0; r < 8; r++) begin drive(0, 0, 0, 1); cyc(); end
    chk("blink_conc", 64'(cc[2]), 64'd1);
    drive(0, 0, 0, 0); cyc();
    chk("blink_0", pad[2], FIM_C);
    for (int r = 0; r < 2; r++) begin drive(0, 0, 0, 1); cyc(); end
    drive(0, 0, 0, 0); cyc();
    chk("blink_1", pad[2], PISCA ? 64'd0 : FIM_C);
    for (int r = 0; r < 2; r++) begin drive(0, 0, 0, 1); cyc(); end
    drive(0, 0, 0, 0); cyc();
    chk("blink_2", pad[2], FIM_C);
    chk("blink_quadro", 64'(qd[2]), 64'd3);
    // Random traffic against the model.
    for (int n = 0; n < 5000; n++) begin
      drive($urandom_range(499) == 0, $urandom_range(149) == 0, $urandom_range(299) == 0,
            $urandom_range(3) != 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
